// File: rtl/button_led_panel_host_if.sv
// Button/LED panel host bus.
// Bundles the UART pins and the panel-side signals of button_led_panel_host.
//   rx         : UART line from device TX (idle high)
//   tx         : UART line to device RX (idle high)
//   buttons_in : raw button levels, rising edge = press
//   leds_out   : last valid LED frame received
//   led_valid  : one-cycle pulse when leds_out updates
//   frame_err  : one-cycle pulse on RX stop-bit error
//   link_up    : a valid frame was seen recently
//   tx_busy    : a command byte is being shifted out
// slave modport = the host block, master modport = whatever drives it.
interface button_led_panel_host_if #(
    parameter int NUM_BUTTONS = 24
);
    logic                   rx;
    logic                   tx;
    logic [NUM_BUTTONS-1:0] buttons_in;
    logic [7:0]             leds_out;
    logic                   led_valid;
    logic                   frame_err;
    logic                   link_up;
    logic                   tx_busy;

    modport slave (
        input  rx, buttons_in,
        output tx, leds_out, led_valid, frame_err, link_up, tx_busy
    );

    modport master (
        output rx, buttons_in,
        input  tx, leds_out, led_valid, frame_err, link_up, tx_busy
    );
endinterface

// File: rtl/button_led_panel_host.sv
// Button/LED panel host: far end of the button/LED UART link.
// Button presses (rising edges) are queued in a pending mask and sent as
// index bytes, lowest index first. Incoming 1-byte frames update the LED bus.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of button_led_panel_host_if (UART pins, buttons,
//           LED bus, led_valid/frame_err pulses, link_up, tx_busy)
module button_led_panel_host #(
    parameter int CLKS_PER_BIT = 87,
    parameter int STALE_CLKS   = 4000,
    parameter int NUM_BUTTONS  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    button_led_panel_host_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int SW = $clog2(STALE_CLKS) + 1;
    localparam int IW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CLKS);
    localparam logic [SW-1:0] STALE_PRE = SW'(STALE_CLKS - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. rx_d is a third stage used only for start-edge
    // detection, so a frame whose stop bit was low cannot re-trigger until
    // the line has gone back high.
    // ------------------------------------------------------------------
    logic                   rx_s1, rx_s2, rx_d;
    logic [NUM_BUTTONS-1:0] btn_s1, btn_s2, btn_prev;
    logic [NUM_BUTTONS-1:0] btn_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            rx_s1    <= bus.rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            btn_s1   <= bus.buttons_in;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_edge = btn_s2 & ~btn_prev;

    // ------------------------------------------------------------------
    // Pending mask and lowest-index scheduler
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0] pending, clr;
    logic [IW-1:0]          sel;
    logic                   load;

    always_comb begin
        sel = '0;
        // Scan downwards so the lowest set index wins.
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending[i]) sel = IW'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (load) clr[sel] = 1'b1;
    end

    // A new edge on the bit being loaded keeps it set: the press arrived
    // after the byte was committed, so it earns another command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr) | btn_edge;
    end

    // ------------------------------------------------------------------
    // TX FSM. The line is registered, so the start bit appears one clock
    // after the load decision.
    // ------------------------------------------------------------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        load       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                if (|pending) begin
                    load       = 1'b1;
                    tx_shift_n = 8'(sel);
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FSM: falling edge -> half-bit recheck -> mid-bit samples
    // ------------------------------------------------------------------
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_ok, rx_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_ok      = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s2 && rx_d) rx_state_n = RX_START;
            end
            RX_START: begin
                // Line back high at mid-start is a glitch: drop it silently.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_ok      = rx_s2;
                    rx_bad     = ~rx_s2;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // LED outputs and link staleness
    // ------------------------------------------------------------------
    logic [7:0]    leds;
    logic          led_pulse, err_pulse, link;
    logic [SW-1:0] stale_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds      <= '0;
            led_pulse <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            if (rx_ok) leds <= rx_shift;
            led_pulse <= rx_ok;
            err_pulse <= rx_bad;
        end
    end

    // Counter restarts on each good frame and parks at STALE_MAX; link drops
    // on the increment that reaches it. Framing errors leave it running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt <= '0;
            link      <= 1'b0;
        end else if (led_pulse) begin
            stale_cnt <= '0;
            link      <= 1'b1;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + 1'b1;
            if (stale_cnt == STALE_PRE) link <= 1'b0;
        end
    end

    assign bus.tx        = tx_line;
    assign bus.tx_busy   = (tx_state != TX_IDLE);
    assign bus.leds_out  = leds;
    assign bus.led_valid = led_pulse;
    assign bus.frame_err = err_pulse;
    assign bus.link_up   = link;
endmodule
